// File: rtl/ej5_bcd_multiplier.sv
// Single-digit BCD multiplier: two BCD digits in, packed two-digit BCD product out.
// Registered outputs, one-cycle latency, one product per clock.
module ej5_bcd_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  output logic [7:0] y,
  output logic       out_valid,
  output logic       err
);

  logic        illegal;
  logic [7:0]  prod_bin;
  logic [11:0] bcd;
  logic [7:0]  y_d;

  logic [7:0]  y_q;
  logic        valid_q;
  logic        err_q;

  // Double-dabble on the binary product. The hundreds nibble only matters for
  // out-of-range digits, whose result is forced to zero anyway.
  always_comb begin
    illegal  = (x1 > 4'd9) || (x2 > 4'd9);
    prod_bin = {4'b0000, x1} * {4'b0000, x2};
    bcd      = 12'h000;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], prod_bin[i]};
    end
    y_d = illegal ? 8'h00 : bcd[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (in_valid) begin
      y_q     <= y_d;
      valid_q <= 1'b1;
      err_q   <= illegal;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ej5_bcd_multiplier.sv
// Self-checking bench for ej5_bcd_multiplier: directed vector table, exhaustive
// digit sweep against a div/mod model, and hand-written multi-cycle sequences.
module tb_ej5_bcd_multiplier;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] x1;
  logic [3:0] x2;
  logic [7:0] y;
  logic       out_valid;
  logic       err;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [3:0] x1;
    logic [3:0] x2;
    logic [7:0] exp_y;
    logic       exp_err;
  } vec_t;

  vec_t vecs[14];

  ej5_bcd_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .y         (y),
    .out_valid (out_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after an edge, then sample 1 ns after the next edge.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    rst      = r;
    in_valid = v;
    x1       = a;
    x2       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [7:0] ey, input logic ev,
                           input logic ee);
    check({name, ".y"}, y, ey);
    check({name, ".out_valid"}, {7'b0, out_valid}, {7'b0, ev});
    check({name, ".err"}, {7'b0, err}, {7'b0, ee});
  endtask

  initial begin
    int p;
    logic [7:0] ey;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{4'd7, 4'd8, 8'b0101_0110, 1'b0};
    vecs[1]  = '{4'd9, 4'd9, 8'h81, 1'b0};
    vecs[2]  = '{4'd5, 4'd2, 8'h10, 1'b0};
    vecs[3]  = '{4'd0, 4'd9, 8'h00, 1'b0};
    vecs[4]  = '{4'd1, 4'd7, 8'h07, 1'b0};
    vecs[5]  = '{4'd8, 4'd5, 8'h40, 1'b0};
    vecs[6]  = '{4'd6, 4'd7, 8'h42, 1'b0};
    vecs[7]  = '{4'd4, 4'd5, 8'h20, 1'b0};
    vecs[8]  = '{4'd9, 4'd1, 8'h09, 1'b0};
    vecs[9]  = '{4'hA, 4'd3, 8'h00, 1'b1};
    vecs[10] = '{4'd2, 4'hF, 8'h00, 1'b1};
    vecs[11] = '{4'd3, 4'd3, 8'h09, 1'b0};
    vecs[12] = '{4'hC, 4'hC, 8'h00, 1'b1};
    vecs[13] = '{4'd8, 4'd9, 8'h72, 1'b0};

    rst = 1'b1; in_valid = 1'b0; x1 = 4'd0; x2 = 4'd0;
    #1;

    // Reset with a valid 9x9 held on the input: must stay cleared.
    step(1'b1, 1'b1, 4'd9, 4'd9);
    step(1'b1, 1'b1, 4'd9, 4'd9);
    check_out("reset", 8'h00, 1'b0, 1'b0);

    // Directed table, back to back.
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].x1, vecs[i].x2);
      check_out($sformatf("vec%0d", i), vecs[i].exp_y, 1'b1, vecs[i].exp_err);
    end

    // Exhaustive legal sweep, one pair per clock.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        step(1'b0, 1'b1, 4'(a), 4'(b));
        p  = a * b;
        ey = {4'(p / 10), 4'(p % 10)};
        check_out($sformatf("sweep%0dx%0d", a, b), ey, 1'b1, 1'b0);
      end
    end

    // Illegal digit then a legal one clears err.
    step(1'b0, 1'b1, 4'hA, 4'd3);
    check_out("illegal", 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd9, 4'd9);
    check_out("illegal_hold", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd3, 4'd3);
    check_out("after_illegal", 8'h09, 1'b1, 1'b0);

    // Hold: idle input with different operands must not disturb y.
    step(1'b0, 1'b1, 4'd6, 4'd4);
    check_out("hold_load", 8'h24, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd9, 4'd9);
    check_out("hold1", 8'h24, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd9, 4'd9);
    check_out("hold2", 8'h24, 1'b0, 1'b0);

    // Reset mid-stream discards the coincident valid input.
    step(1'b0, 1'b1, 4'd2, 4'd3);
    check_out("mid_2x3", 8'h06, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd4, 4'd4);
    check_out("mid_rst", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd4, 4'd4);
    check_out("mid_idle", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd8, 4'd8);
    check_out("mid_8x8", 8'h64, 1'b1, 1'b0);

    // Reset also clears a sticky err.
    step(1'b0, 1'b1, 4'd5, 4'hB);
    check_out("err_set", 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    check_out("err_rst", 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
